instruction_fetch_sequencer: RTL and testbench

- Owns the program counter and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Decodes the branch-relevant fields and drives them into the branch unit: branch_control_signal, funct, branch_address and pc_in.
- Accepts pc_next back from the branch unit when the execute stage signals completion, and loads it into the PC.
- Forms the fetch/issue end of the PC/branch loop.

---
 rtl/instruction_fetch_sequencer.sv | 118 +++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_sequencer.sv
// Fetch/issue end of the PC/branch loop: owns the PC, fetches one instruction at a
// time over a req/ack handshake and presents decoded branch fields to the branch unit.
module instruction_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        exec_ready,
  output logic [31:0] pc_in,
  output logic [1:0]  branch_control_signal,
  output logic [4:0]  funct,
  output logic [31:0] branch_address,
  output logic        halted,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic [31:0] retired_q;

  logic [5:0]         opcode;
  logic signed [31:0] offset_s;
  logic [31:0]        branch_address_d;
  logic [31:0]        retired_d;

  function automatic logic [1:0] branch_class(input logic [5:0] op);
    case (op)
      6'b000011: branch_class = 2'b01;
      6'b000100: branch_class = 2'b10;
      6'b000101: branch_class = 2'b11;
      default:   branch_class = 2'b00;
    endcase
  endfunction

  // Decode is purely combinational from the captured instruction word.
  assign opcode           = instr_q[31:26];
  assign offset_s         = {{11{instr_q[25]}}, instr_q[25:5]};
  assign branch_address_d = pc_q + 32'd1 + offset_s;
  assign retired_d        = retired_q + 32'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (exec_ready) begin
            retired_q <= retired_d;
            valid_q   <= 1'b0;
            if (opcode == HALT_OPCODE) begin
              halted_q <= 1'b1;
              state_q  <= HALTED;
            end else begin
              pc_q    <= pc_next;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req              = req_q;
  assign imem_addr             = pc_q;
  assign pc_in                 = pc_q;
  assign instr                 = instr_q;
  assign instr_valid           = valid_q;
  assign halted                = halted_q;
  assign retired_count         = retired_q;
  assign funct                 = instr_q[4:0];
  assign branch_address        = branch_address_d;
  assign branch_control_signal = (state_q == ISSUE) ? branch_class(opcode) : 2'b00;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer: a vector table walking the
// fetch/issue loop, then hand sequences for reset, delayed ack, stall and halt.
module tb_instruction_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        exec_ready;
  logic [31:0] pc_in;
  logic [1:0]  branch_control_signal;
  logic [4:0]  funct;
  logic [31:0] branch_address;
  logic        halted;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch_sequencer #(
    .RESET_PC   (32'd0),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .pc_next              (pc_next),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_ack             (imem_ack),
    .imem_rdata           (imem_rdata),
    .instr_valid          (instr_valid),
    .instr                (instr),
    .exec_ready           (exec_ready),
    .pc_in                (pc_in),
    .branch_control_signal(branch_control_signal),
    .funct                (funct),
    .branch_address       (branch_address),
    .halted               (halted),
    .retired_count        (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        er;
    logic [31:0] pn;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [1:0]  e_bcs;
    logic [4:0]  e_funct;
    logic [31:0] e_baddr;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic er,
                              input logic [31:0] pn, input logic e_req, input logic [31:0] e_pc,
                              input logic e_valid, input logic [1:0] e_bcs, input logic [4:0] e_funct,
                              input logic [31:0] e_baddr, input logic [31:0] e_ret);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.er = er; v.pn = pn;
    v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid; v.e_bcs = e_bcs;
    v.e_funct = e_funct; v.e_baddr = e_baddr; v.e_ret = e_ret;
    return v;
  endfunction

  logic [31:0] i_a, i_b, i_c, i_d, i_e, i_f, i_halt;

  initial begin
    i_a    = {6'b000011, 21'd5, 5'd7};
    i_b    = {6'b000100, 21'h1FFFFD, 5'd3};
    i_c    = {6'b000101, 21'd0, 5'd0};
    i_d    = {6'b001000, 21'h100000, 5'd31};
    i_e    = {6'b000100, 21'd2, 5'd0};
    i_f    = {6'b000011, 21'd4, 5'd9};
    i_halt = {6'b111111, 26'd0};

    //           ack rdata  er pn            req pc            vld bcs    fn     baddr          ret
    vecs[0]  = mk(1, 32'd0, 0, 32'd0,        1, 32'd0,         0, 2'b00, 5'd0,  32'd1,         32'd0);
    vecs[1]  = mk(1, i_a,   0, 32'd0,        0, 32'd0,         1, 2'b01, 5'd7,  32'd6,         32'd0);
    vecs[2]  = mk(0, 32'd0, 1, 32'd10,       1, 32'd10,        0, 2'b00, 5'd7,  32'd16,        32'd1);
    vecs[3]  = mk(1, i_b,   1, 32'h99,       0, 32'd10,        1, 2'b10, 5'd3,  32'd8,         32'd1);
    vecs[4]  = mk(0, 32'd0, 1, 32'd8,        1, 32'd8,         0, 2'b00, 5'd3,  32'd6,         32'd2);
    vecs[5]  = mk(1, i_c,   0, 32'd0,        0, 32'd8,         1, 2'b11, 5'd0,  32'd9,         32'd2);
    vecs[6]  = mk(1, i_a,   0, 32'd0,        0, 32'd8,         1, 2'b11, 5'd0,  32'd9,         32'd2);
    vecs[7]  = mk(0, 32'd0, 1, 32'd11,       1, 32'd11,        0, 2'b00, 5'd0,  32'd12,        32'd3);
    vecs[8]  = mk(1, i_d,   0, 32'd0,        0, 32'd11,        1, 2'b00, 5'd31, 32'hFFF0000C,  32'd3);
    vecs[9]  = mk(0, 32'd0, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF,  0, 2'b00, 5'd31, 32'hFFF00000,  32'd4);
    vecs[10] = mk(1, i_e,   0, 32'd0,        0, 32'hFFFFFFFF,  1, 2'b10, 5'd0,  32'd2,         32'd4);
    vecs[11] = mk(0, 32'd0, 1, 32'h20,       1, 32'h20,        0, 2'b00, 5'd0,  32'h23,        32'd5);

    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; exec_ready = 1'b0; pc_next = 32'd0;
    #2;
    chk("rst_req",     imem_req, 32'd0);
    chk("rst_pc",      pc_in, 32'd0);
    chk("rst_instr",   instr, 32'd0);
    chk("rst_valid",   instr_valid, 32'd0);
    chk("rst_halted",  halted, 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    chk("rst_bcs",     branch_control_signal, 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Table-driven walk around the fetch/issue loop.
    for (int i = 0; i < 12; i++) begin
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      exec_ready = vecs[i].er; pc_next = vecs[i].pn;
      tick();
      chk($sformatf("v%0d_req", i),   imem_req, vecs[i].e_req);
      chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_pc);
      chk($sformatf("v%0d_pc", i),    pc_in, vecs[i].e_pc);
      chk($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_bcs", i),   branch_control_signal, vecs[i].e_bcs);
      chk($sformatf("v%0d_funct", i), funct, vecs[i].e_funct);
      chk($sformatf("v%0d_baddr", i), branch_address, vecs[i].e_baddr);
      chk($sformatf("v%0d_ret", i),   retired_count, vecs[i].e_ret);
      chk($sformatf("v%0d_halt", i),  halted, 32'd0);
    end

    // Asynchronous reset in the middle of a FETCH at 0x20.
    imem_ack = 1'b0; exec_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_req", imem_req, 32'd0);
    chk("async_pc",  pc_in, 32'd0);
    chk("async_ret", retired_count, 32'd0);
    imem_ack = 1'b1;
    tick();
    tick();
    chk("inrst_req", imem_req, 32'd0);
    reset = 1'b1; imem_ack = 1'b0;
    tick();
    chk("refetch_req",  imem_req, 32'd1);
    chk("refetch_addr", imem_addr, 32'd0);

    // Ack delayed three cycles: request and address must hold.
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'hDEAD0000 + 32'(i);
      tick();
      chk($sformatf("dly%0d_req", i),   imem_req, 32'd1);
      chk($sformatf("dly%0d_addr", i),  imem_addr, 32'd0);
      chk($sformatf("dly%0d_valid", i), instr_valid, 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = i_f;
    tick();
    chk("dly_instr", instr, i_f);
    chk("dly_valid", instr_valid, 32'd1);
    chk("dly_req",   imem_req, 32'd0);

    // Execute stalls five cycles; ack noise must not disturb the issued word.
    for (int i = 0; i < 5; i++) begin
      exec_ready = 1'b0; imem_ack = i[0]; imem_rdata = $urandom;
      tick();
      chk($sformatf("st%0d_valid", i), instr_valid, 32'd1);
      chk($sformatf("st%0d_instr", i), instr, i_f);
      chk($sformatf("st%0d_bcs", i),   branch_control_signal, 32'd1);
      chk($sformatf("st%0d_funct", i), funct, 32'd9);
      chk($sformatf("st%0d_baddr", i), branch_address, 32'd5);
      chk($sformatf("st%0d_req", i),   imem_req, 32'd0);
      chk($sformatf("st%0d_pc", i),    pc_in, 32'd0);
    end
    exec_ready = 1'b1; pc_next = 32'd11; imem_ack = 1'b0;
    tick();
    chk("st_next_req",  imem_req, 32'd1);
    chk("st_next_addr", imem_addr, 32'd11);
    chk("st_next_ret",  retired_count, 32'd1);

    // HALT instruction retires once and stops fetching for good.
    exec_ready = 1'b0; imem_ack = 1'b1; imem_rdata = i_halt;
    tick();
    chk("h_valid", instr_valid, 32'd1);
    chk("h_bcs",   branch_control_signal, 32'd0);
    exec_ready = 1'b1; pc_next = 32'h55; imem_ack = 1'b0;
    tick();
    chk("h_halted", halted, 32'd1);
    chk("h_req",    imem_req, 32'd0);
    chk("h_valid0", instr_valid, 32'd0);
    chk("h_pc",     pc_in, 32'd11);
    chk("h_ret",    retired_count, 32'd2);
    for (int i = 0; i < 4; i++) begin
      imem_ack = i[0]; exec_ready = ~i[0]; imem_rdata = 32'd0;
      tick();
      chk($sformatf("hl%0d_halted", i), halted, 32'd1);
      chk($sformatf("hl%0d_req", i),    imem_req, 32'd0);
      chk($sformatf("hl%0d_valid", i),  instr_valid, 32'd0);
      chk($sformatf("hl%0d_ret", i),    retired_count, 32'd2);
      chk($sformatf("hl%0d_pc", i),     pc_in, 32'd11);
      chk($sformatf("hl%0d_bcs", i),    branch_control_signal, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
